// File: rtl/pwm_capture_if.sv
// PWM capture bus: the measured waveform going in and the recovered timing coming out.
// The DUT takes the slave view; whatever drives pwm_in and consumes results takes the master view.
interface pwm_capture_if #(
    parameter int unsigned W = 12
) ();
    logic         pwm_in;
    logic [W-1:0] duty;
    logic [W-1:0] period;
    logic         valid;
    logic         sat;
    logic         stuck_high;
    logic         stuck_low;

    modport slave (
        input  pwm_in,
        output duty,
        output period,
        output valid,
        output sat,
        output stuck_high,
        output stuck_low
    );

    modport master (
        output pwm_in,
        input  duty,
        input  period,
        input  valid,
        input  sat,
        input  stuck_high,
        input  stuck_low
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rising-to-rising period of an asynchronous PWM input
// in clk cycles, with saturation reporting and stuck-high/stuck-low detection.
module pwm_capture #(
    parameter int unsigned W       = 12,
    parameter int unsigned TIMEOUT = 8192
) (
    input logic          clk,
    input logic          rst,
    pwm_capture_if.slave bus
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    localparam logic [W:0]       CntOne  = (W + 1)'(1);
    localparam logic [W:0]       CntSat  = (W + 1)'(1) << W;
    localparam logic [IdleW-1:0] IdleOne = IdleW'(1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

    typedef enum logic [1:0] {
        StWaitRise,
        StHigh,
        StLow
    } state_e;

    // Counters stop at 2^W so the MSB doubles as a sticky overflow marker.
    function automatic logic [W:0] sat_inc(input logic [W:0] c);
        sat_inc = (c == CntSat) ? c : c + CntOne;
    endfunction

    function automatic logic [W-1:0] clip(input logic [W:0] c);
        clip = c[W] ? {W{1'b1}} : c[W-1:0];
    endfunction

    // Synchronizer, edge history and warm-up
    logic       s1_q, s2_q, p_q;
    logic [1:0] prime_q, prime_d;
    logic       primed, rise, fall, sync_edge;

    // Measurement state
    state_e           state_q, state_d;
    logic [W:0]       hi_q, hi_d;
    logic [W:0]       per_q, per_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             report, timeout;

    // Registered outputs
    logic [W-1:0] duty_q, duty_d;
    logic [W-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         sat_q, sat_d;
    logic         stuck_high_q, stuck_high_d;
    logic         stuck_low_q, stuck_low_d;

    // Two-flop synchronizer plus history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            p_q     <= 1'b0;
            prime_q <= 2'd0;
        end else begin
            s1_q    <= bus.pwm_in;
            s2_q    <= s1_q;
            p_q     <= s2_q;
            prime_q <= prime_d;
        end
    end

    // Edges are only trusted once s2 and p both hold real samples, so an input that is
    // already high out of reset does not look like a rising edge.
    always_comb begin
        prime_d   = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
        primed    = (prime_q == 2'd3);
        rise      = primed & s2_q & ~p_q;
        fall      = primed & ~s2_q & p_q;
        sync_edge = rise | fall;
    end

    // Idle watchdog: restarts on every synchronized edge, parks at TIMEOUT.
    always_comb begin
        idle_d = idle_q;
        if (sync_edge) begin
            idle_d = '0;
        end else if (idle_q != IdleMax) begin
            idle_d = idle_q + IdleOne;
        end
        timeout = (idle_d == IdleMax);
    end

    // State, counter and watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StWaitRise;
            hi_q    <= '0;
            per_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            per_q   <= per_d;
            idle_q  <= idle_d;
        end
    end

    // Next-state and counter logic; a rising edge in StLow completes and restarts in one cycle.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        per_d   = per_q;
        report  = 1'b0;

        unique case (state_q)
            StWaitRise: begin
                if (rise) begin
                    hi_d    = CntOne;
                    per_d   = CntOne;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                per_d = sat_inc(per_q);
                if (fall) begin
                    state_d = StLow;
                end else begin
                    hi_d = sat_inc(hi_q);
                end
            end
            StLow: begin
                if (rise) begin
                    report  = 1'b1;
                    hi_d    = CntOne;
                    per_d   = CntOne;
                    state_d = StHigh;
                end else begin
                    per_d = sat_inc(per_q);
                end
            end
            default: begin
                state_d = StWaitRise;
                hi_d    = '0;
                per_d   = '0;
            end
        endcase

        // Timeout never coincides with an edge, so it cannot swallow a report.
        if (timeout) begin
            state_d = StWaitRise;
            hi_d    = '0;
            per_d   = '0;
        end
    end

    // Output next-state: results latch on completion, stuck flags follow the watchdog.
    always_comb begin
        duty_d       = duty_q;
        period_d     = period_q;
        sat_d        = sat_q;
        valid_d      = report;
        stuck_high_d = timeout & s2_q;
        stuck_low_d  = timeout & ~s2_q;
        if (report) begin
            duty_d   = clip(hi_q);
            period_d = clip(per_q);
            sat_d    = hi_q[W] | per_q[W];
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_q       <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            sat_q        <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            duty_q       <= duty_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            sat_q        <= sat_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.period     = period_q;
    assign bus.valid      = valid_q;
    assign bus.sat        = sat_q;
    assign bus.stuck_high = stuck_high_q;
    assign bus.stuck_low  = stuck_low_q;

endmodule
